// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding icache request at a time, fetched {pc, inst} pairs queued for the issuer.
// Optional macro FETCH_JAL_PREDICT_EN redirects the fetch pc on JAL instructions.
module inst_fetcher #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          IQ_DEPTH  = 8,
   parameter int          IQ_ADDR_W = 3
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        reset_from_rob_bus,
   input  logic [31:0] pc_from_rob_bus,
   output logic        valid_to_icache,
   output logic [31:0] addr_to_icache,
   input  logic        ready_from_icache,
   input  logic        valid_from_icache,
   input  logic [31:0] inst_from_icache,
   output logic        valid_to_issuer,
   output logic [31:0] inst_to_issuer,
   output logic [31:0] pc_to_issuer,
   input  logic        ready_from_issuer
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   localparam logic [IQ_ADDR_W:0] DEPTH_CNT = (IQ_ADDR_W + 1)'(IQ_DEPTH);

   state_t               state;
   state_t               state_next;
   logic [31:0]          pc;
   logic [31:0]          pc_next;
   logic [31:0]          pc_step;
   logic [IQ_ADDR_W-1:0] head;
   logic [IQ_ADDR_W-1:0] tail;
   logic [IQ_ADDR_W:0]   count;
   logic [IQ_ADDR_W:0]   count_next;
   logic [31:0]          pc_mem   [IQ_DEPTH];
   logic [31:0]          inst_mem [IQ_DEPTH];
   logic                 flush;
   logic                 handshake;
   logic                 response;
   logic                 push;
   logic                 pop;

   assign flush     = rdy_in & reset_from_rob_bus;
   assign handshake = rdy_in & (state == REQ) & ready_from_icache;
   assign response  = rdy_in & valid_from_icache;
   assign push      = ~flush & (state == WAIT) & response;
   assign pop       = ~flush & rdy_in & valid_to_issuer & ready_from_issuer;

`ifdef FETCH_JAL_PREDICT_EN
   logic [31:0] jal_imm;
   assign jal_imm = {{11{inst_from_icache[31]}}, inst_from_icache[31], inst_from_icache[19:12],
                     inst_from_icache[20], inst_from_icache[30:21], 1'b0};
   assign pc_step = (inst_from_icache[6:0] == 7'b1101111) ? jal_imm : 32'd4;
`else
   assign pc_step = 32'd4;
`endif

   assign valid_to_icache = (state == REQ);
   assign addr_to_icache  = (state == REQ) ? pc : 32'h0;
   assign valid_to_issuer = (count != '0);
   assign inst_to_issuer  = inst_mem[head];
   assign pc_to_issuer    = pc_mem[head];

   // A flush empties the queue and re-steers the fetch; an in-flight request must be drained in DROP.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      count_next = count;
      if (flush) begin
         pc_next    = pc_from_rob_bus;
         count_next = '0;
         case (state)
            IDLE:    state_next = IDLE;
            REQ:     state_next = handshake ? DROP : IDLE;
            WAIT:    state_next = response ? IDLE : DROP;
            DROP:    state_next = response ? IDLE : DROP;
            default: state_next = IDLE;
         endcase
      end else if (rdy_in) begin
         count_next = count + (IQ_ADDR_W + 1)'(push) - (IQ_ADDR_W + 1)'(pop);
         case (state)
            IDLE:    if (count < DEPTH_CNT) state_next = REQ;
            REQ:     if (handshake) state_next = WAIT;
            WAIT: begin
               if (response) begin
                  pc_next    = pc + pc_step;
                  state_next = (count_next < DEPTH_CNT) ? REQ : IDLE;
               end
            end
            DROP:    if (response) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state <= IDLE;
         pc    <= RESET_PC;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (rdy_in) begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
         if (flush) begin
            head <= '0;
            tail <= '0;
         end else begin
            if (pop)  head <= head + 1'b1;
            if (push) tail <= tail + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) begin
         pc_mem[tail]   <= pc;
         inst_mem[tail] <= inst_from_icache;
      end
   end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed self-checking bench for inst_fetcher: stream, queue fill, flushes, stall and JAL redirect.
module tb_inst_fetcher;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        rdy_in;
   logic        reset_from_rob_bus;
   logic [31:0] pc_from_rob_bus;
   logic        valid_to_icache;
   logic [31:0] addr_to_icache;
   logic        ready_from_icache;
   logic        valid_from_icache;
   logic [31:0] inst_from_icache;
   logic        valid_to_issuer;
   logic [31:0] inst_to_issuer;
   logic [31:0] pc_to_issuer;
   logic        ready_from_issuer;

   int checks = 0;
   int errors = 0;

   inst_fetcher dut (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .rdy_in(rdy_in),
      .reset_from_rob_bus(reset_from_rob_bus),
      .pc_from_rob_bus(pc_from_rob_bus),
      .valid_to_icache(valid_to_icache),
      .addr_to_icache(addr_to_icache),
      .ready_from_icache(ready_from_icache),
      .valid_from_icache(valid_from_icache),
      .inst_from_icache(inst_from_icache),
      .valid_to_issuer(valid_to_issuer),
      .inst_to_issuer(inst_to_issuer),
      .pc_to_issuer(pc_to_issuer),
      .ready_from_issuer(ready_from_issuer)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n_in = 1'b0;
      tick();
      tick();
      rst_n_in = 1'b1;
   endtask

   task automatic wait_req();
      int n;
      n = 0;
      while (valid_to_icache !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("req_timeout", {31'b0, valid_to_icache}, 32'd1);
   endtask

   task automatic flush_to(input logic [31:0] target);
      reset_from_rob_bus = 1'b1;
      pc_from_rob_bus    = target;
      tick();
      reset_from_rob_bus = 1'b0;
   endtask

   // Accept the pending request and return the given word on the following cycle.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word);
      wait_req();
      chk("req_addr", addr_to_icache, exp_addr);
      ready_from_icache = 1'b1;
      tick();
      ready_from_icache = 1'b0;
      valid_from_icache = 1'b1;
      inst_from_icache  = word;
      tick();
      valid_from_icache = 1'b0;
   endtask

   initial begin
      logic [31:0] jal_exp;
      rdy_in             = 1'b1;
      reset_from_rob_bus = 1'b0;
      pc_from_rob_bus    = 32'h0;
      ready_from_icache  = 1'b0;
      valid_from_icache  = 1'b0;
      inst_from_icache   = 32'h0;
      ready_from_issuer  = 1'b1;

      do_reset();
      chk("rst_valid_icache", {31'b0, valid_to_icache}, 32'd0);
      chk("rst_addr_icache", addr_to_icache, 32'h0);
      chk("rst_valid_issuer", {31'b0, valid_to_issuer}, 32'd0);

      // Streaming with an always-ready issuer
      for (int i = 0; i < 4; i++) begin
         fetch(32'(i * 4), 32'h0000_0013 | 32'(i << 20));
         chk("stream_valid", {31'b0, valid_to_issuer}, 32'd1);
         chk("stream_pc", pc_to_issuer, 32'(i * 4));
         chk("stream_inst", inst_to_issuer, 32'h0000_0013 | 32'(i << 20));
      end

      // Fill the queue with the issuer stalled
      do_reset();
      ready_from_issuer = 1'b0;
      for (int i = 0; i < 8; i++) fetch(32'(i * 4), 32'h0000_0093 + 32'(i << 7));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("full_no_req", {31'b0, valid_to_icache}, 32'd0);
      end
      chk("full_head_pc", pc_to_issuer, 32'h0);
      ready_from_issuer = 1'b1;
      tick();
      ready_from_issuer = 1'b0;
      chk("pop_head_pc", pc_to_issuer, 32'h4);
      chk("pop_head_inst", inst_to_issuer, 32'h0000_0113);
      chk("pop_no_req_yet", {31'b0, valid_to_icache}, 32'd0);
      tick();
      chk("refill_req", {31'b0, valid_to_icache}, 32'd1);
      fetch(32'h20, 32'h0000_0513);
      tick();
      chk("refill_once_a", {31'b0, valid_to_icache}, 32'd0);
      tick();
      chk("refill_once_b", {31'b0, valid_to_icache}, 32'd0);

      // Flush while waiting on the pc=8 response
      do_reset();
      fetch(32'h0, 32'h0000_0013);
      fetch(32'h4, 32'h0010_0013);
      wait_req();
      chk("wait_addr", addr_to_icache, 32'h8);
      ready_from_icache = 1'b1;
      tick();
      ready_from_icache = 1'b0;
      flush_to(32'h100);
      chk("fw_queue_cleared", {31'b0, valid_to_issuer}, 32'd0);
      chk("fw_drop_no_req", {31'b0, valid_to_icache}, 32'd0);
      valid_from_icache = 1'b1;
      inst_from_icache  = 32'hDEAD_BEEF;
      tick();
      valid_from_icache = 1'b0;
      chk("fw_stale_dropped", {31'b0, valid_to_issuer}, 32'd0);
      chk("fw_idle_no_req", {31'b0, valid_to_icache}, 32'd0);
      tick();
      chk("fw_req_valid", {31'b0, valid_to_icache}, 32'd1);
      fetch(32'h100, 32'h0020_0013);
      chk("fw_first_pc", pc_to_issuer, 32'h100);
      chk("fw_first_inst", inst_to_issuer, 32'h0020_0013);

      // Flush in REQ without handshake, then flush coincident with a handshake
      flush_to(32'h40);
      chk("fr_no_req", {31'b0, valid_to_icache}, 32'd0);
      chk("fr_queue_cleared", {31'b0, valid_to_issuer}, 32'd0);
      tick();
      chk("fr_req_t2", {31'b0, valid_to_icache}, 32'd1);
      chk("fr_addr_t2", addr_to_icache, 32'h40);
      ready_from_icache = 1'b1;
      flush_to(32'h200);
      ready_from_icache = 1'b0;
      chk("fh_drop_no_req", {31'b0, valid_to_icache}, 32'd0);
      tick();
      tick();
      chk("fh_drop_hold", {31'b0, valid_to_icache}, 32'd0);
      valid_from_icache = 1'b1;
      inst_from_icache  = 32'hBAD0_BAD0;
      tick();
      valid_from_icache = 1'b0;
      chk("fh_stale_dropped", {31'b0, valid_to_issuer}, 32'd0);
      fetch(32'h200, 32'h0030_0013);
      chk("fh_first_pc", pc_to_issuer, 32'h200);

      // Freeze with rdy_in low while in WAIT
      ready_from_icache = 1'b1;
      tick();
      ready_from_icache = 1'b0;
      rdy_in            = 1'b0;
      ready_from_issuer = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("frz_valid", {31'b0, valid_to_issuer}, 32'd1);
         chk("frz_pc", pc_to_issuer, 32'h200);
         chk("frz_no_req", {31'b0, valid_to_icache}, 32'd0);
      end
      rdy_in            = 1'b1;
      valid_from_icache = 1'b1;
      inst_from_icache  = 32'h0040_0013;
      tick();
      valid_from_icache = 1'b0;
      chk("res_valid", {31'b0, valid_to_issuer}, 32'd1);
      chk("res_pc", pc_to_issuer, 32'h204);
      chk("res_inst", inst_to_issuer, 32'h0040_0013);
      chk("res_req_addr", addr_to_icache, 32'h208);

      // JAL at pc=0x20
      flush_to(32'h20);
      fetch(32'h20, 32'h0100_006F);
      chk("jal_entry_pc", pc_to_issuer, 32'h20);
`ifdef FETCH_JAL_PREDICT_EN
      jal_exp = 32'h30;
`else
      jal_exp = 32'h24;
`endif
      wait_req();
      chk("jal_next_addr", addr_to_icache, jal_exp);

      // PC wraps past the top of the address space
      flush_to(32'hFFFF_FFFC);
      fetch(32'hFFFF_FFFC, 32'h0050_0013);
      chk("wrap_entry_pc", pc_to_issuer, 32'hFFFF_FFFC);
      wait_req();
      chk("wrap_next_addr", addr_to_icache, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
Front-end fetch stage, directly downstream of rob_bus: consumes the ROB flush/redirect (reset + target pc) and feeds the issuer. Holds the fetch PC and issues one-word requests to the icache, one outstanding at a time. Buffers fetched {pc, inst} pairs in a small instruction queue the issuer pops. A stale response still in flight when a flush arrives is absorbed and discarded.

Parameters:
RESET_PC, 32'h0, fetch PC after reset
IQ_DEPTH, 8, instruction queue entries (power of two, ≥2)
IQ_ADDR_W, 3, log2(IQ_DEPTH)

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_n_in  input  1  synchronous, active-low reset
rdy_in  input  1  global enable; low freezes all state
reset_from_rob_bus  input  1  flush/redirect request
pc_from_rob_bus  input  32  redirect target
valid_to_icache  output  1  fetch request valid
addr_to_icache  output  32  fetch address
ready_from_icache  input  1  request accepted this cycle
valid_from_icache  input  1  response valid (single cycle)
inst_from_icache  input  32  response instruction word
valid_to_issuer  output  1  queue non-empty
inst_to_issuer  output  32  head instruction
pc_to_issuer  output  32  head pc
ready_from_issuer  input  1  issuer pops head when valid

Behaviour:
- Reset (rst_n_in=0 at edge): pc=RESET_PC, state=IDLE, head=tail=count=0; valid_to_icache=0, addr_to_icache=0, valid_to_issuer=0.
- rdy_in=0: no state change, no push/pop. Icache guarantees no response or acceptance while rdy_in=0.
- States: IDLE, REQ, WAIT, DROP.
- IDLE: if count<IQ_DEPTH, go REQ next cycle. valid_to_icache=0.
- REQ: valid_to_icache=1, addr_to_icache=pc; both held stable until ready_from_icache=1, then WAIT.
- WAIT: on valid_from_icache, push {pc, inst_from_icache} at tail; pc<=pc+4 (mod 2^32). Next state REQ if post-push count<IQ_DEPTH, else IDLE.
- DROP: a stale request is outstanding. On valid_from_icache, discard the data and go IDLE. No push.
- Queue outputs are combinational from the head entry. valid_to_issuer=(count!=0). Pop = valid_to_issuer & ready_from_issuer. Push and pop in the same cycle leave count unchanged. Pointers wrap mod IQ_DEPTH.
- Full queue: no request is issued. At most one outstanding request always has a free slot, because a request leaves REQ only with count<IQ_DEPTH and no other push source exists.
- Flush (reset_from_rob_bus=1, rdy_in=1) has priority over everything else:
  - Queue cleared: head=tail=count=0. Any pop in the same cycle is ignored.
  - pc<=pc_from_rob_bus.
  - Next state from IDLE: IDLE.
  - Next state from REQ without handshake: IDLE, valid_to_icache drops next cycle.
  - Next state from REQ with handshake in the same cycle: DROP.
  - Next state from WAIT without response: DROP.
  - Next state from WAIT with response in the same cycle: IDLE, response discarded.
  - Next state from DROP without response: DROP, new pc kept.
  - Next state from DROP with response in the same cycle: IDLE.
  - Back-to-back flushes: the last one wins.
- Latency:
  - Flush cycle t → request at new pc visible cycle t+2 (IDLE→REQ), provided no drop is pending.
  - Response cycle r → entry visible to issuer cycle r+1.

Optional Feature:
FETCH_JAL_PREDICT_EN — when defined, a pushed instruction with opcode[6:0]=7'b1101111 (JAL) sets next pc = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) instead of pc+4. The entry's pc_to_issuer is unchanged. A flush overrides the prediction in the same cycle. When undefined, next pc is always pc+4.

Test Plan:
- Reset then stream: icache ready=1, response 1 cycle after accept; issuer always ready → pcs 0,4,8,12 delivered in order with the matching inst words, no gaps or duplicates.
- Queue fill: ready_from_issuer=0 → after 8 pushes count=8, valid_to_icache stays 0. Pop one → exactly one new request, at pc=32.
- Flush in WAIT: flush to 0x100 while awaiting the pc=8 response → response dropped, queue empty, next request addr=0x100, first issuer entry pc=0x100.
- Flush coincident with REQ handshake at pc=0x40, target 0x200 → DROP; stale response discarded; next request addr=0x200.
- rdy_in=0 for 5 cycles mid-WAIT with issuer ready → valid/pc/count outputs frozen; resumes identically afterwards.
- FETCH_JAL_PREDICT_EN: inst 0x0100006F (jal x0,+16) at pc=0x20 → next request addr=0x30. With the macro undefined → next request addr=0x24.
